// File: rtl/arith_unit_seq.sv
// Sequential signed arithmetic unit: 1-cycle add/sub/mul, iterative restoring divide.
// Define ARITH_REM_EN to add the Arith_Rem remainder port.
module arith_unit_seq #(
    parameter int WIDTH = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic signed [WIDTH-1:0]   A,
    input  logic signed [WIDTH-1:0]   B,
    input  logic [1:0]                Arith_ALU_op,
    input  logic                      In_Valid,
    output logic                      In_Ready,
    output logic signed [2*WIDTH-1:0] Arith_Out,
    output logic                      Out_Valid,
    output logic                      Div_By_Zero,
`ifdef ARITH_REM_EN
    output logic signed [WIDTH-1:0]   Arith_Rem,
`endif
    output logic [1:0]                dbg_state
);

    // Handshake: an op is taken when In_Valid && In_Ready at a rising edge;
    // In_Ready is high only in IDLE, Out_Valid pulses for exactly one cycle per result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t                      state;
    logic [CW-1:0]               cnt;
    logic [WIDTH:0]              mag_b;
    logic [WIDTH-1:0]            quo;
    logic [WIDTH-1:0]            rem;
    logic                        q_sign;
`ifdef ARITH_REM_EN
    logic                        r_sign;
`endif

    logic signed [2*WIDTH-1:0]   a_ext;
    logic signed [2*WIDTH-1:0]   b_ext;
    logic [WIDTH-1:0]            a_mag;
    logic [WIDTH:0]              b_mag;
    logic [WIDTH:0]              shifted;
    logic                        take;
    logic [2*WIDTH-1:0]          q_ext;

    assign a_ext   = (2*WIDTH)'(A);
    assign b_ext   = (2*WIDTH)'(B);
    // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is still correct read as unsigned.
    assign a_mag   = A[WIDTH-1] ? WIDTH'(-A) : WIDTH'(A);
    assign b_mag   = B[WIDTH-1] ? -((WIDTH+1)'(B)) : (WIDTH+1)'(B);
    assign shifted = {rem, quo[WIDTH-1]};
    assign take    = (shifted >= mag_b);
    assign q_ext   = {{WIDTH{1'b0}}, quo};

    assign In_Ready  = (state == IDLE);
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            cnt         <= '0;
            mag_b       <= '0;
            quo         <= '0;
            rem         <= '0;
            q_sign      <= 1'b0;
            Arith_Out   <= '0;
            Out_Valid   <= 1'b0;
            Div_By_Zero <= 1'b0;
`ifdef ARITH_REM_EN
            r_sign      <= 1'b0;
            Arith_Rem   <= '0;
`endif
        end else begin
            Out_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (In_Valid) begin
                        if (Arith_ALU_op != 2'b11) begin
                            case (Arith_ALU_op)
                                2'b00:   Arith_Out <= a_ext + b_ext;
                                2'b01:   Arith_Out <= a_ext - b_ext;
                                default: Arith_Out <= a_ext * b_ext;
                            endcase
                            Out_Valid   <= 1'b1;
                            Div_By_Zero <= 1'b0;
`ifdef ARITH_REM_EN
                            Arith_Rem   <= '0;
`endif
                        end else if (B == '0) begin
                            Arith_Out   <= '0;
                            Out_Valid   <= 1'b1;
                            Div_By_Zero <= 1'b1;
`ifdef ARITH_REM_EN
                            Arith_Rem   <= A;
`endif
                        end else begin
                            quo    <= a_mag;
                            rem    <= '0;
                            mag_b  <= b_mag;
                            q_sign <= A[WIDTH-1] ^ B[WIDTH-1];
`ifdef ARITH_REM_EN
                            r_sign <= A[WIDTH-1];
`endif
                            cnt    <= '0;
                            state  <= DIV;
                        end
                    end
                end
                DIV: begin
                    // Dividend bits shift out of quo's top while quotient bits enter at the bottom.
                    quo <= {quo[WIDTH-2:0], take};
                    rem <= take ? WIDTH'(shifted - mag_b) : WIDTH'(shifted);
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    Arith_Out   <= q_sign ? -q_ext : q_ext;
                    Out_Valid   <= 1'b1;
                    Div_By_Zero <= 1'b0;
`ifdef ARITH_REM_EN
                    Arith_Rem   <= r_sign ? -rem : rem;
`endif
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
